// File: rtl/cc_pkg.sv
// Shared constants and types for the ChaCha20 block-core arbiter.
package cc_pkg;
    localparam int KEY_W = 256;
    localparam int NON_W = 96;
    localparam int CNT_W = 32;
    localparam int BLK_W = 512;
    localparam int WD_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;
endpackage

// File: rtl/cc_rr_pick.sv
// Two-way round-robin picker: the index other than 'last' wins a tie,
// a lone requester always wins.
module cc_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       sel
);
    // Purely combinational winner selection.
    always_comb begin
        valid = |req;
        sel   = req[1];
        if (req == 2'b11) begin
            sel = ~last;
        end
    end
endmodule

// File: rtl/cc_block_arb.sv
// Shares one cc_block keystream core between two requesters: latches the
// winner's operands, fires a one-cycle start, returns the block with a
// per-requester done pulse and reports a hung core through a watchdog.
module cc_block_arb
    import cc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0,
    input  logic             i_req1,
    input  logic [KEY_W-1:0] i_key0,
    input  logic [KEY_W-1:0] i_key1,
    input  logic [NON_W-1:0] i_non0,
    input  logic [NON_W-1:0] i_non1,
    input  logic [CNT_W-1:0] i_cnt0,
    input  logic [CNT_W-1:0] i_cnt1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_done0,
    output logic             o_done1,
    output logic             o_err,
    output logic [BLK_W-1:0] o_stream,
    output logic             o_blk_start,
    output logic [KEY_W-1:0] o_blk_key,
    output logic [NON_W-1:0] o_blk_non,
    output logic [CNT_W-1:0] o_blk_cnt,
    input  logic [BLK_W-1:0] i_blk_stream,
    input  logic             i_blk_done
);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            r_last;
    logic            r_sel;
    logic            sel_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;
    logic            pick_valid;
    logic            pick_sel;

    cc_rr_pick u_pick (
        .req   ({i_req1, i_req0}),
        .last  (r_last),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // A completion in the same cycle as the last watchdog count takes priority.
    assign wd_fire = (state == WAIT) && !i_blk_done && (wd_cnt == WD_LAST);

    // Next-state decode; the owner is only re-chosen while idle.
    always_comb begin
        state_nxt = state;
        sel_nxt   = r_sel;
        case (state)
            IDLE: begin
                sel_nxt = pick_sel;
                if (pick_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (i_blk_done || wd_fire) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control registers and registered outputs, derived from the next state
    // so every output is valid in the cycle of the state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            wd_cnt      <= '0;
            o_blk_start <= 1'b0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_done0     <= 1'b0;
            o_done1     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (state == IDLE && pick_valid) begin
                r_sel <= pick_sel;
            end
            if (state == RESP) begin
                r_last <= r_sel;
            end
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT && wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            o_blk_start <= (state_nxt == ISSUE);
            o_gnt0      <= (state_nxt != IDLE) && !sel_nxt;
            o_gnt1      <= (state_nxt != IDLE) && sel_nxt;
            o_done0     <= (state_nxt == RESP) && !r_sel;
            o_done1     <= (state_nxt == RESP) && r_sel;
            o_err       <= wd_fire;
        end
    end

    // Operand latch at grant and keystream capture (zeroed on watchdog abort).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_blk_key <= '0;
            o_blk_non <= '0;
            o_blk_cnt <= '0;
            o_stream  <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                o_blk_key <= pick_sel ? i_key1 : i_key0;
                o_blk_non <= pick_sel ? i_non1 : i_non0;
                o_blk_cnt <= pick_sel ? i_cnt1 : i_cnt0;
            end
            if (state == WAIT) begin
                if (i_blk_done) begin
                    o_stream <= i_blk_stream;
                end else if (wd_fire) begin
                    o_stream <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cc_block_arb.sv
// Scoreboard bench for cc_block_arb. Three instances: index 0 uses the
// default TIMEOUT (64), index 1 uses TIMEOUT=16, index 2 uses TIMEOUT=10.
// Each has a core stub with latency lat[g] whose block is {key,non,cnt,TAIL}.
module tb_cc_block_arb;
    import cc_pkg::*;

    localparam logic [127:0]   TAIL  = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [511:0]   STRAY = {16{32'hdeadbeef}};
    localparam logic [NON_W-1:0] NON_A = 96'h000000090000004a00000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [2:0]       req0, req1, gnt0, gnt1, done0, done1, err;
    logic [2:0]       blk_start, blk_done, force_done, stray_sel, hang;
    logic [KEY_W-1:0] key0 [3];
    logic [KEY_W-1:0] key1 [3];
    logic [KEY_W-1:0] blk_key [3];
    logic [NON_W-1:0] non0 [3];
    logic [NON_W-1:0] non1 [3];
    logic [NON_W-1:0] blk_non [3];
    logic [CNT_W-1:0] cnt0 [3];
    logic [CNT_W-1:0] cnt1 [3];
    logic [CNT_W-1:0] blk_cnt [3];
    logic [BLK_W-1:0] stream [3];
    logic [BLK_W-1:0] blk_stream [3];
    int               lat [3];

    typedef struct {
        int           inst;
        logic [1:0]   who;
        logic         err;
        logic [511:0] stream;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   start_log[$];
    logic mon_en = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        int           remaining = 0;
        logic [511:0] strm = '0;

        cc_block_arb #(.TIMEOUT(g == 0 ? 64 : (g == 1 ? 16 : 10))) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_req0       (req0[g]),
            .i_req1       (req1[g]),
            .i_key0       (key0[g]),
            .i_key1       (key1[g]),
            .i_non0       (non0[g]),
            .i_non1       (non1[g]),
            .i_cnt0       (cnt0[g]),
            .i_cnt1       (cnt1[g]),
            .o_gnt0       (gnt0[g]),
            .o_gnt1       (gnt1[g]),
            .o_done0      (done0[g]),
            .o_done1      (done1[g]),
            .o_err        (err[g]),
            .o_stream     (stream[g]),
            .o_blk_start  (blk_start[g]),
            .o_blk_key    (blk_key[g]),
            .o_blk_non    (blk_non[g]),
            .o_blk_cnt    (blk_cnt[g]),
            .i_blk_stream (blk_stream[g]),
            .i_blk_done   (blk_done[g])
        );

        // Core stub: done is high lat cycles after the start cycle.
        always @(posedge clk) begin
            if (blk_start[g] === 1'b1) begin
                remaining <= hang[g] ? 0 : lat[g];
                strm      <= {blk_key[g], blk_non[g], blk_cnt[g], TAIL};
            end else if (remaining > 0) begin
                remaining <= remaining - 1;
            end
        end
        assign blk_done[g]   = (remaining == 1) || force_done[g];
        assign blk_stream[g] = stray_sel[g] ? STRAY : strm;
    end

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] blk_of(logic [255:0] k, logic [95:0] n, logic [31:0] c);
        return {k, n, c, TAIL};
    endfunction

    function automatic logic [255:0] seq_key(int base);
        logic [255:0] k;
        for (int i = 0; i < 32; i++) k[255-8*i -: 8] = 8'(base + i);
        return k;
    endfunction

    task automatic push(int inst, logic [1:0] who, logic e, logic [511:0] s, int c);
        exp_t x;
        x.inst = inst; x.who = who; x.err = e; x.stream = s; x.cyc = c;
        exp_q.push_back(x);
    endtask

    // Advance negedge by negedge until instance g shows a done, bounded.
    task automatic wait_done(int g, int bound, output logic [1:0] saw_gnt);
        int n = 0;
        saw_gnt = 2'b00;
        while (!(done0[g] || done1[g]) && n < bound) begin
            saw_gnt = saw_gnt | {gnt1[g], gnt0[g]};
            @(negedge clk);
            n++;
        end
        saw_gnt = saw_gnt | {gnt1[g], gnt0[g]};
        if (!(done0[g] || done1[g])) chk($sformatf("wait_done_timeout_inst%0d", g), 512'(0), 512'(1));
    endtask

    task automatic chk_zero(string tag, int g);
        chk({tag, "_gnt0"},   512'(gnt0[g]),      '0);
        chk({tag, "_gnt1"},   512'(gnt1[g]),      '0);
        chk({tag, "_done"},   512'({done1[g], done0[g]}), '0);
        chk({tag, "_err"},    512'(err[g]),       '0);
        chk({tag, "_start"},  512'(blk_start[g]), '0);
        chk({tag, "_key"},    512'(blk_key[g]),   '0);
        chk({tag, "_non"},    512'(blk_non[g]),   '0);
        chk({tag, "_cnt"},    512'(blk_cnt[g]),   '0);
        chk({tag, "_stream"}, stream[g],          '0);
    endtask

    // Monitor: pops the scoreboard whenever any instance presents a done.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (blk_start[0]) start_log.push_back(cyc);
            for (int g = 0; g < 3; g++) begin
                if (done0[g] || done1[g]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_done_inst%0d", g), 512'({done1[g], done0[g]}), '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_inst",   512'(g),                   512'(e.inst));
                        chk("done_who",    512'({done1[g], done0[g]}), 512'(e.who));
                        chk("done_err",    512'(err[g]),              512'(e.err));
                        chk("done_stream", stream[g],                 e.stream);
                        chk("done_cycle",  512'(cyc),                 512'(e.cyc));
                    end
                end else if (err[g]) begin
                    chk($sformatf("err_without_done_inst%0d", g), 512'(err[g]), '0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0]   sg;
        logic [255:0] ka, kb, kc, kd;
        logic         seen, changed;
        int           n;

        rst = 1'b1;
        req0 = '0; req1 = '0; force_done = '0; stray_sel = '0; hang = '0;
        lat = '{10, 10, 10};
        for (int g = 0; g < 3; g++) begin
            key0[g] = '0; key1[g] = '0; non0[g] = '0; non1[g] = '0; cnt0[g] = '0; cnt1[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) chk_zero($sformatf("reset_inst%0d", g), g);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single requester, key 00..1f, counter 1.
        ka = seq_key(0);
        n = cyc;
        key0[0] = ka; non0[0] = NON_A; cnt0[0] = 32'd1; req0[0] = 1'b1;
        push(0, 2'b01, 1'b0, blk_of(ka, NON_A, 32'd1), n + 12);
        @(negedge clk);
        chk("s1_start",    512'(blk_start[0]), 512'(1));
        chk("s1_blk_cnt",  512'(blk_cnt[0]),   512'(1));
        chk("s1_blk_key",  512'(blk_key[0]),   512'(ka));
        chk("s1_blk_non",  512'(blk_non[0]),   512'(NON_A));
        chk("s1_gnt0",     512'(gnt0[0]),      512'(1));
        @(negedge clk);
        chk("s1_start_once", 512'(blk_start[0]), '0);
        wait_done(0, 20, sg);
        chk("s1_no_gnt1", 512'(sg[1]), '0);
        req0[0] = 1'b0;
        @(negedge clk);
        chk("s1_idle_gnt0", 512'(gnt0[0]), '0);

        // Simultaneous requests right after reset: 0 first, then 1.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        start_log.delete();
        ka = seq_key(8'h40); kb = seq_key(8'h80);
        n = cyc;
        key0[0] = ka; non0[0] = 96'h111; cnt0[0] = 32'd5; req0[0] = 1'b1;
        key1[0] = kb; non1[0] = 96'h222; cnt1[0] = 32'd7; req1[0] = 1'b1;
        push(0, 2'b01, 1'b0, blk_of(ka, 96'h111, 32'd5), n + 12);
        push(0, 2'b10, 1'b0, blk_of(kb, 96'h222, 32'd7), n + 25);
        wait_done(0, 30, sg);
        req0[0] = 1'b0;
        @(negedge clk);
        wait_done(0, 30, sg);
        req1[0] = 1'b0;
        chk("s2_start_count", 512'(start_log.size()), 512'(2));
        if (start_log.size() >= 2) begin
            chk("s2_first_start", 512'(start_log[0]), 512'(n + 1));
            chk("s2_start_gap",   512'(start_log[1] - start_log[0]), 512'(13));
        end

        // Fairness: both held for six operations, counters bumped after each.
        @(negedge clk);
        n = cyc;
        cnt0[0] = 32'd100; cnt1[0] = 32'd200;
        req0[0] = 1'b1; req1[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push(0, 2'b01, 1'b0, blk_of(ka, 96'h111, 32'(100 + k / 2)), n + 12 + 13 * k);
            else            push(0, 2'b10, 1'b0, blk_of(kb, 96'h222, 32'(200 + k / 2)), n + 12 + 13 * k);
        end
        for (int k = 0; k < 6; k++) begin
            wait_done(0, 20, sg);
            if (done0[0]) cnt0[0] = cnt0[0] + 32'd1;
            if (done1[0]) cnt1[0] = cnt1[0] + 32'd1;
            if (k == 5) begin
                req0[0] = 1'b0; req1[0] = 1'b0;
            end
            @(negedge clk);
        end

        // Watchdog on instance 1 (TIMEOUT=16), then a normal operation.
        hang[1] = 1'b1;
        n = cyc;
        kc = seq_key(8'hc0);
        key0[1] = kc; non0[1] = 96'h333; cnt0[1] = 32'd3; req0[1] = 1'b1;
        push(1, 2'b01, 1'b1, '0, n + 18);
        wait_done(1, 40, sg);
        req0[1] = 1'b0; hang[1] = 1'b0;
        @(negedge clk);
        n = cyc;
        cnt0[1] = 32'd4; req0[1] = 1'b1;
        push(1, 2'b01, 1'b0, blk_of(kc, 96'h333, 32'd4), n + 12);
        wait_done(1, 20, sg);
        req0[1] = 1'b0;
        @(negedge clk);

        // Reset four cycles after start; the stub's later done must be ignored.
        n = cyc;
        cnt0[0] = 32'd9; req0[0] = 1'b1;
        @(negedge clk);
        chk("s5_start", 512'(blk_start[0]), 512'(1));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("s5_after_rst", 0);
        rst = 1'b0; req0[0] = 1'b0;
        seen = 1'b0; changed = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen    = seen | blk_done[0];
            changed = changed | done0[0] | done1[0] | (stream[0] != '0);
        end
        chk("s5_stub_done_seen", 512'(seen), 512'(1));
        chk("s5_no_response",    512'(changed), '0);

        // Stray done in IDLE with a different stream on the core bus.
        stray_sel[0] = 1'b1; force_done[0] = 1'b1;
        @(negedge clk);
        force_done[0] = 1'b0;
        changed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            changed = changed | done0[0] | done1[0] | err[0] | gnt0[0] | gnt1[0] | blk_start[0];
        end
        chk("s6_stray_ctrl",   512'(changed), '0);
        chk("s6_stray_stream", stream[0], '0);
        stray_sel[0] = 1'b0;

        // Done coincides with the last watchdog count (instance 2, TIMEOUT=10).
        @(negedge clk);
        n = cyc;
        kd = seq_key(8'he0);
        key1[2] = kd; non1[2] = 96'h444; cnt1[2] = 32'd0; req1[2] = 1'b1;
        push(2, 2'b10, 1'b0, blk_of(kd, 96'h444, 32'd0), n + 12);
        wait_done(2, 20, sg);
        req1[2] = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_drained", 512'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
